// File: rtl/join_responder_pkg.sv
// Shared types and default constants for the join responder and its stall watchdog.
package join_responder_pkg;

   typedef enum logic [0:0] {
      COLLECT = 1'b0,
      RESPOND = 1'b1
   } state_e;

   localparam int unsigned DEF_ACK_VAL  = 32'd42;
   localparam int unsigned DEF_NACK_VAL = 32'd0;
   localparam int unsigned DEF_TIMEOUT  = 32'd16;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'hFF) begin
         r = v;
      end else begin
         r = v + 8'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/join_responder_stall_watchdog.sv
// Saturating stall counter with a sticky deadlock flag raised when the count
// reaches TIMEOUT; only a reset clears the flag.
module stall_watchdog
   import join_responder_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic stall,
   input  logic clear,
   output logic deadlock
);

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   logic [7:0] count_r;
   logic [7:0] count_nxt_s;
   logic       deadlock_r;

   // Next count: clear wins over stall, otherwise saturating increment.
   always_comb begin
      count_nxt_s = count_r;
      if (clear) begin
         count_nxt_s = 8'd0;
      end else if (stall) begin
         count_nxt_s = sat_inc8(count_r);
      end else begin
         count_nxt_s = 8'd0;
      end
   end

   // Counter and sticky flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r    <= 8'd0;
         deadlock_r <= 1'b0;
      end else begin
         count_r    <= count_nxt_s;
         deadlock_r <= deadlock_r | (count_nxt_s >= TIMEOUT_C);
      end
   end

   assign deadlock = deadlock_r;

endmodule

// File: rtl/join_responder.sv
// Joins one request from channel A and one from channel B, then answers on C
// with ACK_VAL if either captured payload is nonzero, NACK_VAL otherwise.
module join_responder
   import join_responder_pkg::*;
#(
   parameter int unsigned DW       = 8,
   parameter int unsigned ACK_VAL  = DEF_ACK_VAL,
   parameter int unsigned NACK_VAL = DEF_NACK_VAL,
   parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_valid,
   output logic          a_ready,
   input  logic [DW-1:0] a_data,
   input  logic          b_valid,
   output logic          b_ready,
   input  logic [DW-1:0] b_data,
   output logic          c_valid,
   input  logic          c_ready,
   output logic [DW-1:0] c_data,
   output logic          c_ack,
   output logic          deadlock,
   output logic [7:0]    txn_count
);

   localparam logic [DW-1:0] ACK_C  = DW'(ACK_VAL);
   localparam logic [DW-1:0] NACK_C = DW'(NACK_VAL);

   state_e        state_r,     state_nxt_s;
   logic          a_got_r,     a_got_nxt_s;
   logic          b_got_r,     b_got_nxt_s;
   logic [DW-1:0] a_flag_r,    a_flag_nxt_s;
   logic [DW-1:0] b_flag_r,    b_flag_nxt_s;
   logic          a_ready_r,   a_ready_nxt_s;
   logic          b_ready_r,   b_ready_nxt_s;
   logic          c_valid_r,   c_valid_nxt_s;
   logic [DW-1:0] c_data_r,    c_data_nxt_s;
   logic          c_ack_r,     c_ack_nxt_s;
   logic [7:0]    txn_count_r, txn_count_nxt_s;

   logic a_xfer_s;
   logic b_xfer_s;
   logic c_hs_s;
   logic resp_ack_s;
   logic stall_s;
   logic clear_s;

   assign a_xfer_s   = a_valid && a_ready_r;
   assign b_xfer_s   = b_valid && b_ready_r;
   assign c_hs_s     = c_valid_r && c_ready;
   assign resp_ack_s = |(a_flag_r | b_flag_r);

   // Stalled means waiting on the missing partner or on a blocked response.
   assign stall_s = ((state_r == COLLECT) && (a_got_r ^ b_got_r)) ||
                    ((state_r == RESPOND) && !c_ready);
   assign clear_s = !stall_s || a_xfer_s || b_xfer_s;

   // Next-state and datapath decode for the collect/respond handshake.
   always_comb begin
      state_nxt_s     = state_r;
      a_got_nxt_s     = a_got_r;
      b_got_nxt_s     = b_got_r;
      a_flag_nxt_s    = a_flag_r;
      b_flag_nxt_s    = b_flag_r;
      c_valid_nxt_s   = c_valid_r;
      c_data_nxt_s    = c_data_r;
      c_ack_nxt_s     = c_ack_r;
      txn_count_nxt_s = txn_count_r;
      case (state_r)
         COLLECT: begin
            if (a_xfer_s) begin
               a_got_nxt_s  = 1'b1;
               a_flag_nxt_s = a_data;
            end else begin
               a_got_nxt_s  = a_got_r;
            end
            if (b_xfer_s) begin
               b_got_nxt_s  = 1'b1;
               b_flag_nxt_s = b_data;
            end else begin
               b_got_nxt_s  = b_got_r;
            end
            if (a_got_r && b_got_r) begin
               state_nxt_s   = RESPOND;
               c_valid_nxt_s = 1'b1;
               c_ack_nxt_s   = resp_ack_s;
               c_data_nxt_s  = resp_ack_s ? ACK_C : NACK_C;
            end else begin
               state_nxt_s   = COLLECT;
            end
         end
         RESPOND: begin
            if (c_hs_s) begin
               state_nxt_s     = COLLECT;
               c_valid_nxt_s   = 1'b0;
               a_got_nxt_s     = 1'b0;
               b_got_nxt_s     = 1'b0;
               a_flag_nxt_s    = {DW{1'b0}};
               b_flag_nxt_s    = {DW{1'b0}};
               txn_count_nxt_s = txn_count_r + 8'd1;
            end else begin
               state_nxt_s     = RESPOND;
            end
         end
         default: begin
            state_nxt_s   = COLLECT;
            c_valid_nxt_s = 1'b0;
            a_got_nxt_s   = 1'b0;
            b_got_nxt_s   = 1'b0;
         end
      endcase
      // Ready is registered from the next state so the ports never glitch.
      a_ready_nxt_s = (state_nxt_s == COLLECT) && !a_got_nxt_s;
      b_ready_nxt_s = (state_nxt_s == COLLECT) && !b_got_nxt_s;
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= COLLECT;
         a_got_r     <= 1'b0;
         b_got_r     <= 1'b0;
         a_flag_r    <= {DW{1'b0}};
         b_flag_r    <= {DW{1'b0}};
         a_ready_r   <= 1'b1;
         b_ready_r   <= 1'b1;
         c_valid_r   <= 1'b0;
         c_data_r    <= {DW{1'b0}};
         c_ack_r     <= 1'b0;
         txn_count_r <= 8'd0;
      end else begin
         state_r     <= state_nxt_s;
         a_got_r     <= a_got_nxt_s;
         b_got_r     <= b_got_nxt_s;
         a_flag_r    <= a_flag_nxt_s;
         b_flag_r    <= b_flag_nxt_s;
         a_ready_r   <= a_ready_nxt_s;
         b_ready_r   <= b_ready_nxt_s;
         c_valid_r   <= c_valid_nxt_s;
         c_data_r    <= c_data_nxt_s;
         c_ack_r     <= c_ack_nxt_s;
         txn_count_r <= txn_count_nxt_s;
      end
   end

   stall_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk      (clk),
      .rst      (rst),
      .stall    (stall_s),
      .clear    (clear_s),
      .deadlock (deadlock)
   );

   assign a_ready   = a_ready_r;
   assign b_ready   = b_ready_r;
   assign c_valid   = c_valid_r;
   assign c_data    = c_data_r;
   assign c_ack     = c_ack_r;
   assign txn_count = txn_count_r;

endmodule

// File: tb/tb_join_responder.sv
// Directed bench for join_responder: expected C responses are queued at
// stimulus time and compared when the handshake is observed.
module tb_join_responder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       a_valid = 1'b0, b_valid = 1'b0, c_ready = 1'b0;
   logic [7:0] a_data = 8'd0, b_data = 8'd0;
   logic       a_ready, b_ready, c_valid, c_ack, deadlock;
   logic [7:0] c_data, txn_count;

   int tests = 0;
   int fails = 0;
   int hs_count = 0;
   int a_acc = 0;
   int hs_base;
   int acc_base;
   logic [8:0] exp_q[$];
   logic [8:0] exp_e;

   always #5 clk = ~clk;

   join_responder #(
      .DW(8), .ACK_VAL(42), .NACK_VAL(0), .TIMEOUT(16)
   ) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
      .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data),
      .c_ack(c_ack), .deadlock(deadlock), .txn_count(txn_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference response: {ack, data}
   function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b);
      return ((a | b) != 8'd0) ? {1'b1, 8'd42} : {1'b0, 8'd0};
   endfunction

   // One clock: observe handshakes at the falling edge, then step past the rising edge.
   task automatic tick();
      @(negedge clk);
      if (!rst) begin
         if (a_valid && a_ready) a_acc++;
         if (c_valid && c_ready) begin
            hs_count++;
            check("hs_no_accept", 32'({a_ready, b_ready}), 32'd0);
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               exp_e = exp_q.pop_front();
               check("sb_c_data", 32'(c_data), 32'(exp_e[7:0]));
               check("sb_c_ack", 32'(c_ack), 32'(exp_e[8]));
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; c_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1);
   end

   initial begin
      // Reset state
      do_reset();
      check("rst_a_ready", 32'(a_ready), 32'd1);
      check("rst_b_ready", 32'(b_ready), 32'd1);
      check("rst_c_valid", 32'(c_valid), 32'd0);
      check("rst_c_data", 32'(c_data), 32'd0);
      check("rst_c_ack", 32'(c_ack), 32'd0);
      check("rst_deadlock", 32'(deadlock), 32'd0);
      check("rst_txn_count", 32'(txn_count), 32'd0);

      // A=0 and B=1 together: ACK one cycle after capture
      c_ready = 1'b1;
      a_valid = 1'b1; a_data = 8'd0; b_valid = 1'b1; b_data = 8'd1;
      exp_q.push_back(model(8'd0, 8'd1));
      tick();
      a_valid = 1'b0; b_valid = 1'b0;
      check("t030_latency_c_valid", 32'(c_valid), 32'd0);
      tick();
      check("t030_c_valid", 32'(c_valid), 32'd1);
      check("t030_c_data", 32'(c_data), 32'd42);
      check("t030_c_ack", 32'(c_ack), 32'd1);
      check("t030_a_ready_resp", 32'(a_ready), 32'd0);
      tick();
      check("t030_c_valid_done", 32'(c_valid), 32'd0);
      check("t030_txn_count", 32'(txn_count), 32'd1);
      check("t030_a_ready_back", 32'(a_ready), 32'd1);

      // A=0 then B=0 three cycles later: NACK
      a_valid = 1'b1; a_data = 8'd0;
      tick();
      a_valid = 1'b0;
      tick();
      tick();
      b_valid = 1'b1; b_data = 8'd0;
      exp_q.push_back(model(8'd0, 8'd0));
      check("t031_b_ready", 32'(b_ready), 32'd1);
      tick();
      b_valid = 1'b0;
      check("t031_latency_c_valid", 32'(c_valid), 32'd0);
      tick();
      check("t031_c_valid", 32'(c_valid), 32'd1);
      check("t031_c_data", 32'(c_data), 32'd0);
      check("t031_c_ack", 32'(c_ack), 32'd0);
      check("t031_deadlock", 32'(deadlock), 32'd0);
      tick();
      check("t031_txn_count", 32'(txn_count), 32'd2);

      // 257 back-to-back transactions with valids held high
      do_reset();
      c_ready = 1'b1;
      hs_base = hs_count;
      acc_base = a_acc;
      a_valid = 1'b1; b_valid = 1'b1;
      for (int n = 0; n < 257; n++) begin
         for (int w = 0; w < 10 && !(a_ready && b_ready); w++) tick();
         check("t034_ready_wait", 32'(a_ready && b_ready), 32'd1);
         a_data = 8'($urandom_range(0, 2));
         b_data = 8'($urandom_range(0, 2));
         exp_q.push_back(model(a_data, b_data));
         tick();
      end
      a_valid = 1'b0; b_valid = 1'b0;
      for (int w = 0; w < 10 && exp_q.size() != 0; w++) tick();
      tick();
      check("t034_queue_drained", 32'(exp_q.size()), 32'd0);
      check("t034_txn_count_wrap", 32'(txn_count), 32'd1);
      check("t034_handshakes", 32'(hs_count - hs_base), 32'd257);
      check("t034_a_accepts", 32'(a_acc - acc_base), 32'd257);
      check("t034_deadlock", 32'(deadlock), 32'd0);

      // A=5 and no B: deadlock rises 16 cycles after capture
      do_reset();
      c_ready = 1'b1;
      a_valid = 1'b1; a_data = 8'd5;
      tick();
      a_valid = 1'b0;
      check("t032_a_ready", 32'(a_ready), 32'd0);
      for (int k = 1; k < 16; k++) tick();
      check("t032_deadlock_early", 32'(deadlock), 32'd0);
      check("t032_c_valid", 32'(c_valid), 32'd0);
      tick();
      check("t032_deadlock_rise", 32'(deadlock), 32'd1);
      tick();
      tick();
      tick();
      check("t032_deadlock_sticky", 32'(deadlock), 32'd1);
      check("t032_c_valid_late", 32'(c_valid), 32'd0);
      check("t032_a_ready_late", 32'(a_ready), 32'd0);

      // Response held with c_ready low for 20 cycles
      do_reset();
      check("t033_rst_deadlock", 32'(deadlock), 32'd0);
      a_valid = 1'b1; a_data = 8'd3; b_valid = 1'b1; b_data = 8'd0;
      exp_q.push_back(model(8'd3, 8'd0));
      tick();
      a_valid = 1'b0; b_valid = 1'b0;
      tick();
      check("t033_c_valid", 32'(c_valid), 32'd1);
      for (int k = 0; k < 20; k++) begin
         tick();
         check("t033_hold_c_data", 32'(c_data), 32'd42);
         check("t033_hold_c_valid", 32'(c_valid), 32'd1);
      end
      check("t033_deadlock", 32'(deadlock), 32'd1);
      hs_base = hs_count;
      c_ready = 1'b1;
      tick();
      check("t033_c_valid_done", 32'(c_valid), 32'd0);
      check("t033_collect_a", 32'(a_ready), 32'd1);
      check("t033_collect_b", 32'(b_ready), 32'd1);
      check("t033_txn_count", 32'(txn_count), 32'd1);
      tick();
      tick();
      check("t033_one_handshake", 32'(hs_count - hs_base), 32'd1);

      // Reset one cycle after an A capture discards the transaction
      do_reset();
      c_ready = 1'b1;
      hs_base = hs_count;
      a_valid = 1'b1; a_data = 8'd7;
      tick();
      a_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t035_a_ready", 32'(a_ready), 32'd1);
      check("t035_b_ready", 32'(b_ready), 32'd1);
      check("t035_c_valid", 32'(c_valid), 32'd0);
      check("t035_c_data", 32'(c_data), 32'd0);
      check("t035_c_ack", 32'(c_ack), 32'd0);
      check("t035_deadlock", 32'(deadlock), 32'd0);
      check("t035_txn_count", 32'(txn_count), 32'd0);
      b_valid = 1'b1; b_data = 8'd1;
      tick();
      b_valid = 1'b0;
      tick();
      tick();
      check("t035_no_response", 32'(c_valid), 32'd0);
      check("t035_no_handshake", 32'(hs_count - hs_base), 32'd0);
      check("t035_a_still_ready", 32'(a_ready), 32'd1);
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
